// File: rtl/f_ifu_if.sv
// Fetch-stage signal bundle between the IFU, the decode stage and instruction memory.
// slave = the IFU itself; master = whatever drives redirects and returns instructions.
interface f_ifu_if;
    logic        stall;
    logic        fd_clr;
    logic [1:0]  d_npc_sel;
    logic        d_br_taken;
    logic [15:0] d_imm16;
    logic [25:0] d_imm26;
    logic [31:0] d_rs_val;
    logic [31:0] f_pc;
    logic [31:0] f_instr;
    logic [31:0] d_instr;
    logic [31:0] d_pc;
    logic [31:0] d_pc8;
    logic        d_valid;
    logic        d_exc_adel;

    modport slave (
        input  stall, fd_clr, d_npc_sel, d_br_taken, d_imm16, d_imm26, d_rs_val, f_instr,
        output f_pc, d_instr, d_pc, d_pc8, d_valid, d_exc_adel
    );

    modport master (
        output stall, fd_clr, d_npc_sel, d_br_taken, d_imm16, d_imm26, d_rs_val, f_instr,
        input  f_pc, d_instr, d_pc, d_pc8, d_valid, d_exc_adel
    );
endinterface

// File: rtl/f_ifu.sv
// MIPS fetch stage: PC register, next-PC select, F/D register; one cycle PC-to-F/D latency.
// Backpressure: stall freezes PC and F/D; fd_clr inserts a bubble. Option: FETCH_ADEL_EN.
module f_ifu #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter int          IM_WORDS = 4096
) (
    input  logic     clk,
    input  logic     reset_n,
    f_ifu_if.slave   bus
);

    typedef enum logic [1:0] {
        NPC_SEQ = 2'b00,
        NPC_BR  = 2'b01,
        NPC_J   = 2'b10,
        NPC_JR  = 2'b11
    } npc_sel_e;

    logic [31:0] r_pc;
    logic [31:0] r_d_instr;
    logic [31:0] r_d_pc;
    logic        r_d_valid;
    logic        r_d_exc_adel;

    logic [31:0] w_seq;
    logic [31:0] w_br_off;
    logic [31:0] w_br_tgt;
    logic [31:0] w_j_tgt;
    logic [31:0] w_npc;
    logic        w_adel;
    logic [31:0] w_fetch_instr;

    // Redirect targets are relative to the branch/jump sitting in D, not to f_pc.
    assign w_seq    = r_pc + 32'd4;
    assign w_br_off = {{14{bus.d_imm16[15]}}, bus.d_imm16, 2'b00};
    assign w_br_tgt = r_d_pc + 32'd4 + w_br_off;
    assign w_j_tgt  = {r_d_pc[31:28], bus.d_imm26, 2'b00};

    always_comb begin
        w_npc = w_seq;
        case (npc_sel_e'(bus.d_npc_sel))
            NPC_SEQ: w_npc = w_seq;
            NPC_BR:  w_npc = bus.d_br_taken ? w_br_tgt : w_seq;
            NPC_J:   w_npc = w_j_tgt;
            NPC_JR:  w_npc = bus.d_rs_val;
            default: w_npc = w_seq;
        endcase
    end

`ifdef FETCH_ADEL_EN
    localparam logic [31:0] PC_LAST = PC_RESET + 32'(4 * IM_WORDS) - 32'd4;

    assign w_adel        = (r_pc[1:0] != 2'b00) || (r_pc < PC_RESET) || (r_pc > PC_LAST);
    assign w_fetch_instr = w_adel ? 32'h0000_0000 : bus.f_instr;
`else
    // Instruction-space bound only matters when fetch address checking is built in.
    logic w_unused_im;
    assign w_unused_im   = (IM_WORDS > 0);
    assign w_adel        = 1'b0;
    assign w_fetch_instr = bus.f_instr;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc <= PC_RESET;
        end else if (!bus.stall) begin
            r_pc <= w_npc;
        end
    end

    // fd_clr wins over stall so a bubble can be injected while the PC is frozen.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_d_instr    <= 32'h0000_0000;
            r_d_pc       <= 32'h0000_0000;
            r_d_valid    <= 1'b0;
            r_d_exc_adel <= 1'b0;
        end else if (bus.fd_clr) begin
            r_d_instr    <= 32'h0000_0000;
            r_d_pc       <= r_pc;
            r_d_valid    <= 1'b0;
            r_d_exc_adel <= 1'b0;
        end else if (!bus.stall) begin
            r_d_instr    <= w_fetch_instr;
            r_d_pc       <= r_pc;
            r_d_valid    <= 1'b1;
            r_d_exc_adel <= w_adel;
        end
    end

    assign bus.f_pc       = r_pc;
    assign bus.d_instr    = r_d_instr;
    assign bus.d_pc       = r_d_pc;
    assign bus.d_pc8      = r_d_pc + 32'd8;
    assign bus.d_valid    = r_d_valid;
    assign bus.d_exc_adel = r_d_exc_adel;

endmodule

// File: tb/tb_f_ifu.sv
// Bench for f_ifu: directed redirect/stall/clear vectors, a cycle-level reference model,
// and literal checks on the key PC values.
module tb_f_ifu;

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    f_ifu_if bus ();

    f_ifu #(.PC_RESET(32'h0000_3000), .IM_WORDS(4096)) dut (
        .clk     (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] imem(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5A5, a[15:0]};
    endfunction

    // Instruction memory: combinational read of the current fetch PC.
    always_comb bus.f_instr = imem(bus.f_pc);

    function automatic bit addr_err(input logic [31:0] a);
        longint unsigned u;
        u = a;
        return (u % 4 != 0) || (u < 64'h3000) || (u > 64'h3000 + 4 * 4096 - 4);
    endfunction

    // Reference model state.
    logic [31:0] m_pc, m_d_instr, m_d_pc;
    logic        m_d_valid, m_d_exc;

    function automatic logic [31:0] model_npc();
        longint t;
        case (bus.d_npc_sel)
            2'd1: begin
                if (!bus.d_br_taken) return m_pc + 32'd4;
                t = longint'(m_d_pc) + 4 + longint'($signed(bus.d_imm16)) * 4;
                return t[31:0];
            end
            2'd2:    return (m_d_pc & 32'hF000_0000) | (32'(bus.d_imm26) * 32'd4);
            2'd3:    return bus.d_rs_val;
            default: return m_pc + 32'd4;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc <= 32'h3000; m_d_instr <= '0; m_d_pc <= '0; m_d_valid <= 1'b0; m_d_exc <= 1'b0;
        end else begin
            if (!bus.stall) m_pc <= model_npc();
            if (bus.fd_clr) begin
                m_d_instr <= '0; m_d_pc <= m_pc; m_d_valid <= 1'b0; m_d_exc <= 1'b0;
            end else if (!bus.stall) begin
                m_d_pc    <= m_pc;
                m_d_valid <= 1'b1;
`ifdef FETCH_ADEL_EN
                m_d_exc   <= addr_err(m_pc);
                m_d_instr <= addr_err(m_pc) ? 32'h0 : imem(m_pc);
`else
                m_d_exc   <= 1'b0;
                m_d_instr <= imem(m_pc);
`endif
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("f_pc",       bus.f_pc,               m_pc);
        chk("d_instr",    bus.d_instr,            m_d_instr);
        chk("d_pc",       bus.d_pc,               m_d_pc);
        chk("d_pc8",      bus.d_pc8,              m_d_pc + 32'd8);
        chk("d_valid",    32'(bus.d_valid),       32'(m_d_valid));
        chk("d_exc_adel", 32'(bus.d_exc_adel),    32'(m_d_exc));
    end

    task automatic cyc(input logic [1:0] sel, input logic tk, input logic [15:0] i16,
                       input logic [25:0] i26, input logic [31:0] rs,
                       input logic st, input logic clr);
        bus.d_npc_sel  = sel;
        bus.d_br_taken = tk;
        bus.d_imm16    = i16;
        bus.d_imm26    = i26;
        bus.d_rs_val   = rs;
        bus.stall      = st;
        bus.fd_clr     = clr;
        @(negedge clk);
    endtask

    task automatic seq();
        cyc(2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.d_npc_sel = '0; bus.d_br_taken = 1'b0; bus.d_imm16 = '0; bus.d_imm26 = '0;
        bus.d_rs_val = '0; bus.stall = 1'b0; bus.fd_clr = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_f_pc",  bus.f_pc,  32'h3000);
        chk("rst_d_pc8", bus.d_pc8, 32'h8);
        chk("rst_valid", 32'(bus.d_valid), 32'h0);
        rst_n = 1'b1;

        seq(); chk("seq1_pc", bus.f_pc, 32'h3004); chk("seq1_dpc", bus.d_pc, 32'h3000);
        chk("seq1_valid", 32'(bus.d_valid), 32'h1);
        seq(); chk("seq2_pc", bus.f_pc, 32'h3008);
        seq(); chk("seq3_pc", bus.f_pc, 32'h300C);

        // Mid-operation reset with a pending jr redirect.
        bus.d_npc_sel = 2'd3; bus.d_rs_val = 32'h5000;
        #2 rst_n = 1'b0;
        #1 chk("mid_rst_pc", bus.f_pc, 32'h3000);
        chk("mid_rst_valid", 32'(bus.d_valid), 32'h0);
        @(negedge clk); rst_n = 1'b1;

        seq(); seq();
        chk("pre_br_dpc", bus.d_pc, 32'h3004);
        cyc(2'd1, 1'b1, 16'hFFFF, 26'h0, 32'h0, 1'b0, 1'b0);
        chk("br_pc", bus.f_pc, 32'h3004);
        chk("br_slot_dpc", bus.d_pc, 32'h3008);
        chk("br_slot_instr", bus.d_instr, imem(32'h3008));
        seq();
        cyc(2'd1, 1'b0, 16'hFFFF, 26'h0, 32'h0, 1'b0, 1'b0);
        chk("br_nt_pc", bus.f_pc, 32'h300C);
        seq(); seq();
        chk("pre_j_dpc", bus.d_pc, 32'h3010);
        cyc(2'd2, 1'b0, 16'h0, 26'h0000C40, 32'h0, 1'b0, 1'b0);
        chk("j_pc", bus.f_pc, 32'h3100);
        cyc(2'd3, 1'b0, 16'h0, 26'h0, 32'h3200, 1'b0, 1'b0);
        chk("jr_pc", bus.f_pc, 32'h3200);

        // Taken branch held by a two-cycle stall, then released.
        cyc(2'd1, 1'b1, 16'h0010, 26'h0, 32'h0, 1'b1, 1'b0);
        cyc(2'd1, 1'b1, 16'h0010, 26'h0, 32'h0, 1'b1, 1'b0);
        chk("stall_pc", bus.f_pc, 32'h3200);
        chk("stall_dpc", bus.d_pc, 32'h3100);
        chk("stall_instr", bus.d_instr, imem(32'h3100));
        cyc(2'd1, 1'b1, 16'h0010, 26'h0, 32'h0, 1'b0, 1'b0);
        chk("unstall_pc", bus.f_pc, 32'h3144);

        cyc(2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b1, 1'b1);
        chk("clr_st_instr", bus.d_instr, 32'h0);
        chk("clr_st_valid", 32'(bus.d_valid), 32'h0);
        chk("clr_st_pc", bus.f_pc, 32'h3144);
        chk("clr_st_dpc", bus.d_pc, 32'h3144);
        cyc(2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b1);
        chk("clr_pc", bus.f_pc, 32'h3148);
        seq();

        // Backward branch far below d_pc, and a forward branch with max positive offset.
        cyc(2'd1, 1'b1, 16'h8000, 26'h0, 32'h0, 1'b0, 1'b0);
        seq();
        cyc(2'd1, 1'b1, 16'h7FFF, 26'h0, 32'h0, 1'b0, 1'b0);
        seq();

        // Fetch address checks: misaligned, above range, top word, below range.
        cyc(2'd3, 1'b0, 16'h0, 26'h0, 32'h3202, 1'b0, 1'b0);
        cyc(2'd3, 1'b0, 16'h0, 26'h0, 32'h7000, 1'b0, 1'b0);
        chk("adel_mis_dpc", bus.d_pc, 32'h3202);
`ifdef FETCH_ADEL_EN
        chk("adel_mis_flag",  32'(bus.d_exc_adel), 32'h1);
        chk("adel_mis_instr", bus.d_instr, 32'h0);
`else
        chk("adel_mis_flag",  32'(bus.d_exc_adel), 32'h0);
        chk("adel_mis_instr", bus.d_instr, imem(32'h3202));
`endif
        cyc(2'd3, 1'b0, 16'h0, 26'h0, 32'h6FFC, 1'b0, 1'b0);
        chk("adel_hi_dpc", bus.d_pc, 32'h7000);
`ifdef FETCH_ADEL_EN
        chk("adel_hi_flag", 32'(bus.d_exc_adel), 32'h1);
`else
        chk("adel_hi_flag", 32'(bus.d_exc_adel), 32'h0);
`endif
        cyc(2'd3, 1'b0, 16'h0, 26'h0, 32'h2FFC, 1'b0, 1'b0);
        chk("adel_top_flag", 32'(bus.d_exc_adel), 32'h0);
        seq();
        seq();
        chk("adel_lo_dpc", bus.d_pc, 32'h3000);
        repeat (3) seq();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/f_ifu.md
Name: f_ifu

Overview:
- Fetch stage of the five-stage MIPS pipeline.
- Owns the PC register and drives f_pc to the instruction memory, which returns f_instr combinationally in the same cycle.
- Computes the next PC from D-stage redirect requests: branch, j/jal, jr/jalr. Branch delay slot is architectural.
- Holds the F/D pipeline register that feeds the decoder.

Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset and base of instruction space
- IM_WORDS, 4096, instruction memory depth in words; valid fetch range is PC_RESET to PC_RESET+4*IM_WORDS-4

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- stall  in  1  hazard-unit stall; freezes PC and F/D register
- fd_clr  in  1  clears F/D register to a bubble
- d_npc_sel  in  2  00 = seq, 01 = branch, 10 = j/jal, 11 = jr/jalr
- d_br_taken  in  1  branch comparison result from D; only used when sel = 01
- d_imm16  in  16  branch offset of the instruction in D
- d_imm26  in  26  jump index of the instruction in D
- d_rs_val  in  32  forwarded rs value for jr/jalr
- f_pc  out  32  current fetch PC, sent to instruction memory
- f_instr  in  32  instruction word returned by instruction memory
- d_instr  out  32  F/D register: instruction
- d_pc  out  32  F/D register: PC of d_instr
- d_pc8  out  32  d_pc + 8; link value for jal/jalr
- d_valid  out  1  F/D register holds a real fetched instruction
- d_exc_adel  out  1  fetch address error flag; 0 when the feature is disabled

Behaviour:
- Reset (async, reset_n = 0):
  - f_pc = PC_RESET.
  - d_instr = 0, d_pc = 0, d_valid = 0, d_exc_adel = 0.
  - d_pc8 is combinational, so it equals 8 during reset.
  - Asserting reset mid-operation discards any pending redirect immediately.
- Next-PC computation:
  - seq = f_pc + 4.
  - branch target = d_pc + 4 + (sign-extend(d_imm16) << 2), computed modulo 2^32.
  - jump target = {d_pc[31:28], d_imm26, 2'b00}.
  - jr target = d_rs_val.
  - sel 01 with d_br_taken = 0 selects seq.
  - Redirect targets use d_pc (the branch in D), never f_pc.
  - Because of the delay slot, the instruction at f_pc is always fetched and latched into F/D.
- Per rising edge with stall = 0:
  - f_pc <= selected next PC.
  - d_instr <= f_instr, d_pc <= f_pc, d_valid <= 1.
- stall = 1:
  - f_pc and the whole F/D register hold.
  - A simultaneous redirect is not lost: D is also held, so the same redirect is presented again on the next cycle.
- fd_clr = 1:
  - d_instr <= 0, d_valid <= 0, d_exc_adel <= 0.
  - d_pc <= f_pc, so a precise PC is kept for the bubble.
  - fd_clr beats stall for the F/D register.
  - The PC still obeys stall.
- Latency: an instruction appears in F/D one cycle after its PC is on f_pc.
- No alignment forcing: f_pc is the raw computed value.

Optional Feature:
- Macro: FETCH_ADEL_EN.
- Defined:
  - A fetch is an address error when f_pc[1:0] != 0, or f_pc < PC_RESET, or f_pc > PC_RESET + 4*IM_WORDS - 4.
  - On latch, d_instr <= 0 (nop) instead of f_instr, and d_exc_adel <= 1.
  - d_pc still records the faulting PC.
  - The PC keeps sequencing normally; redirection to a handler belongs to the exception unit.
- Not defined:
  - f_instr always passes through unmodified.
  - d_exc_adel is tied to 0.
  - No range comparators are synthesised.

Test Plan:
- Reset release, no stall, seq for 3 edges:
  - f_pc goes 3000, 3004, 3008, 300C.
  - d_pc tracks one cycle behind; d_valid = 1 from the first edge.
- Branch taken with d_pc = 3004, d_imm16 = 16'hFFFF, d_br_taken = 1:
  - The delay-slot instruction at 3008 enters F/D.
  - Next f_pc = 3004.
- d_br_taken = 0 with sel = 01: f_pc continues 300C.
- j with d_pc = 3010, d_imm26 = 26'h0000C40 → f_pc = 3100. jr with d_rs_val = 3200 → f_pc = 3200.
- stall high 2 cycles during a taken branch:
  - f_pc, d_instr and d_pc frozen.
  - After stall drops, f_pc = branch target.
- fd_clr and stall together: d_instr = 0, d_valid = 0, f_pc held.
- FETCH_ADEL_EN defined:
  - Misaligned jr target 3202 → d_exc_adel = 1, d_instr = 0.
  - jr target 7000 → d_exc_adel = 1.
  - Macro undefined with the same stimulus → d_exc_adel = 0 and d_instr = f_instr.
